uart_rx: RTL and testbench

Serial receiver that feeds the peripheral wrapper's `uart` slot. It converts the asynchronous 8N1 line `uart_in` into a parallel byte plus a level interrupt to `mips_cpu`. It holds each byte and the interrupt until the CPU acknowledges with `cpu_end_read`, and it flags framing and overrun errors.

---
 rtl/uart_pkg.sv | 14 +
 rtl/uart_rx_sync2.sv | 23 ++
 rtl/uart_rx.sv | 119 +++++++++++
 tb/tb_uart_rx.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive path.
package uart_pkg;

  localparam int DEFAULT_CLKS_PER_BIT = 434;
  localparam int DATA_BITS            = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } rx_state_t;

endpackage

// File: rtl/uart_rx_sync2.sv
// Generic two-flop synchronizer with a configurable reset value.
module sync2 #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (!rst) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// 8N1 serial receiver with a level interrupt, CPU acknowledge handshake,
// framing-error pulse and sticky overrun flag.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 uart_in,
  input  logic                 cpu_end_read,
  output logic [DATA_BITS-1:0] read_byte,
  output logic                 read_int,
  output logic                 frame_err,
  output logic                 overrun
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [2:0]    LAST_BIT  = 3'(DATA_BITS - 1);

  rx_state_t            state;
  logic [CW-1:0]        cyc_cnt;
  logic [2:0]           bit_cnt;
  logic [DATA_BITS-1:0] shift;
  logic                 brk;
  logic                 rx_s;

  sync2 #(.RESET_VAL(1'b1)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (uart_in),
    .q   (rx_s)
  );

  // Acknowledge is applied before acceptance so a colliding byte still lands.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      cyc_cnt   <= '0;
      bit_cnt   <= '0;
      shift     <= '0;
      brk       <= 1'b0;
      read_byte <= '0;
      read_int  <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      frame_err <= 1'b0;
      if (cpu_end_read) begin
        read_int <= 1'b0;
        overrun  <= 1'b0;
      end

      case (state)
        IDLE: begin
          cyc_cnt <= '0;
          bit_cnt <= '0;
          brk     <= 1'b0;
          if (!rx_s) state <= START;
        end

        START: begin
          if (cyc_cnt == HALF_LAST) begin
            cyc_cnt <= '0;
            state   <= rx_s ? IDLE : DATA;
          end else begin
            cyc_cnt <= cyc_cnt + 1'b1;
          end
        end

        DATA: begin
          if (cyc_cnt == BIT_LAST) begin
            cyc_cnt <= '0;
            shift   <= {rx_s, shift[DATA_BITS-1:1]};
            if (bit_cnt == LAST_BIT) begin
              bit_cnt <= '0;
              state   <= STOP;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end else begin
            cyc_cnt <= cyc_cnt + 1'b1;
          end
        end

        STOP: begin
          // After a bad stop bit, wait out any break before rearming.
          if (brk) begin
            if (rx_s) begin
              brk   <= 1'b0;
              state <= IDLE;
            end
          end else if (cyc_cnt == BIT_LAST) begin
            cyc_cnt <= '0;
            if (rx_s) begin
              state <= IDLE;
              if (!read_int || cpu_end_read) begin
                read_byte <= shift;
                read_int  <= 1'b1;
              end else begin
                overrun <= 1'b1;
              end
            end else begin
              frame_err <= 1'b1;
              brk       <= 1'b1;
            end
          end else begin
            cyc_cnt <= cyc_cnt + 1'b1;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Directed self-checking bench for uart_rx at 16 clocks per bit.
module tb_uart_rx;

  localparam int CPB = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic       uart_in;
  logic       cpu_end_read;
  logic [7:0] read_byte;
  logic       read_int;
  logic       frame_err;
  logic       overrun;

  int vectors  = 0;
  int fails    = 0;
  int fe_count = 0;
  int fe_base;

  uart_rx #(.CLKS_PER_BIT(CPB)) dut (
    .clk          (clk),
    .rst          (rst),
    .uart_in      (uart_in),
    .cpu_end_read (cpu_end_read),
    .read_byte    (read_byte),
    .read_int     (read_int),
    .frame_err    (frame_err),
    .overrun      (overrun)
  );

  always #5 clk = ~clk;

  // Counts cycles with frame_err high, using the value held before each edge.
  always @(posedge clk) if (frame_err === 1'b1) fe_count++;

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      fails++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Start bit plus eight data bits; leaves the line on the last data bit.
  task automatic sendBits(input logic [7:0] b);
    uart_in = 1'b0;
    tick(CPB);
    for (int i = 0; i < 8; i++) begin
      uart_in = b[i];
      tick(CPB);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] b, input logic stop_bit);
    sendBits(b);
    uart_in = stop_bit;
    tick(CPB);
  endtask

  initial begin
    rst          = 1'b0;
    uart_in      = 1'b1;
    cpu_end_read = 1'b0;
    tick(3);
    checkOutput("reset_read_byte", 32'(read_byte), 32'h00);
    checkOutput("reset_read_int",  32'(read_int),  32'h0);
    checkOutput("reset_frame_err", 32'(frame_err), 32'h0);
    checkOutput("reset_overrun",   32'(overrun),   32'h0);
    rst = 1'b1;
    tick(4);

    // Single byte 0xA5: stop sampled at frame cycle 152, visible one cycle later.
    fe_base = fe_count;
    sendBits(8'hA5);
    uart_in = 1'b1;
    tick(10);
    checkOutput("a5_int_before_stop", 32'(read_int), 32'h0);
    tick(1);
    checkOutput("a5_int_rise",  32'(read_int),  32'h1);
    checkOutput("a5_byte",      32'(read_byte), 32'hA5);
    tick(25);
    checkOutput("a5_byte_hold", 32'(read_byte), 32'hA5);
    checkOutput("a5_int_hold",  32'(read_int),  32'h1);
    checkOutput("a5_no_fe",     32'(fe_count - fe_base), 32'd0);
    checkOutput("a5_no_ovr",    32'(overrun),   32'h0);
    cpu_end_read = 1'b1;
    tick(1);
    cpu_end_read = 1'b0;
    checkOutput("a5_ack_int", 32'(read_int), 32'h0);

    // Glitch of four cycles must be rejected at the start-bit midpoint.
    fe_base = fe_count;
    uart_in = 1'b0;
    tick(4);
    uart_in = 1'b1;
    tick(40);
    checkOutput("glitch_int", 32'(read_int), 32'h0);
    checkOutput("glitch_fe",  32'(fe_count - fe_base), 32'd0);

    // Framing error followed by a held break.
    fe_base = fe_count;
    sendBits(8'h3C);
    uart_in = 1'b0;
    tick(CPB + 40);
    checkOutput("fe_one_pulse", 32'(fe_count - fe_base), 32'd1);
    checkOutput("fe_int",       32'(read_int), 32'h0);
    uart_in = 1'b1;
    tick(30);
    checkOutput("fe_no_retrigger", 32'(fe_count - fe_base), 32'd1);
    checkOutput("fe_int_after",    32'(read_int), 32'h0);

    // Overrun: second byte arrives while the first is unacknowledged.
    applyStimulus(8'h11, 1'b1);
    applyStimulus(8'h22, 1'b1);
    tick(5);
    checkOutput("ovr_byte", 32'(read_byte), 32'h11);
    checkOutput("ovr_int",  32'(read_int),  32'h1);
    checkOutput("ovr_flag", 32'(overrun),   32'h1);
    cpu_end_read = 1'b1;
    tick(1);
    cpu_end_read = 1'b0;
    checkOutput("ovr_ack_int",  32'(read_int), 32'h0);
    checkOutput("ovr_ack_flag", 32'(overrun),  32'h0);

    // Acknowledge lands exactly on the 0x22 stop-sample edge.
    applyStimulus(8'h11, 1'b1);
    sendBits(8'h22);
    uart_in = 1'b1;
    tick(10);
    checkOutput("col_pending", 32'(read_byte), 32'h11);
    cpu_end_read = 1'b1;
    tick(1);
    cpu_end_read = 1'b0;
    checkOutput("col_byte", 32'(read_byte), 32'h22);
    checkOutput("col_int",  32'(read_int),  32'h1);
    checkOutput("col_ovr",  32'(overrun),   32'h0);
    tick(5);
    cpu_end_read = 1'b1;
    tick(1);
    cpu_end_read = 1'b0;
    checkOutput("col_ack_int", 32'(read_int), 32'h0);

    // Reset during data bit 4 of 0xFF, then a clean 0x5A.
    uart_in = 1'b0;
    tick(CPB);
    uart_in = 1'b1;
    tick(4 * CPB + 8);
    rst = 1'b0;
    tick(3);
    checkOutput("rst_mid_byte", 32'(read_byte), 32'h00);
    checkOutput("rst_mid_int",  32'(read_int),  32'h0);
    checkOutput("rst_mid_fe",   32'(frame_err), 32'h0);
    checkOutput("rst_mid_ovr",  32'(overrun),   32'h0);
    rst = 1'b1;
    tick(8 * CPB);
    checkOutput("rst_no_partial", 32'(read_int), 32'h0);
    fe_base = fe_count;
    applyStimulus(8'h5A, 1'b1);
    tick(5);
    checkOutput("rst_5a_byte", 32'(read_byte), 32'h5A);
    checkOutput("rst_5a_int",  32'(read_int),  32'h1);
    checkOutput("rst_5a_ovr",  32'(overrun),   32'h0);
    checkOutput("rst_5a_fe",   32'(fe_count - fe_base), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
